// File: rtl/mure_pkg.sv
// Shared types and field widths for the retire serializer ingress stage.
// Contents:
//   ITYPE_LEN / XLEN / CAUSE_LEN / PRIV_LEN : trace field widths.
//   MaxNrRetired / SlotSelW                  : storage slot count and its index width.
//   ret_slot_s                               : one retired instruction (itype, iaddr, ilastsize).
//   ret_group_s                              : one commit group as stored in the FIFO.
package mure_pkg;

    localparam int unsigned ITYPE_LEN = 3;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CAUSE_LEN = 5;
    localparam int unsigned PRIV_LEN  = 2;

    // Groups are stored with the maximum legal slot count; unused slots are zero-filled.
    localparam int unsigned MaxNrRetired = 8;
    localparam int unsigned SlotSelW     = 3;

    typedef struct packed {
        logic [ITYPE_LEN-1:0] itype;
        logic [XLEN-1:0]      iaddr;
        logic                 ilastsize;
    } ret_slot_s;

    typedef struct packed {
        ret_slot_s [MaxNrRetired-1:0] slot;
        logic [MaxNrRetired-1:0]      valid;
        logic [CAUSE_LEN-1:0]         cause;
        logic [XLEN-1:0]              tval;
        logic [PRIV_LEN-1:0]          priv;
    } ret_group_s;

endpackage

// File: rtl/retire_slot_picker.sv
// Combinational lowest-set-bit finder over a commit-slot mask.
// Ports:
//   mask_i   : slot mask to search.
//   idx_o    : index of the lowest set bit (0 when the mask is empty).
//   found_o  : mask has at least one bit set.
//   onehot_o : mask has exactly one bit set (the picked slot is the last one).
module retire_slot_picker #(
    parameter int unsigned NrRetiredInstr = 2,
    parameter int unsigned IdxW           = 1
) (
    input  logic [NrRetiredInstr-1:0] mask_i,
    output logic [IdxW-1:0]           idx_o,
    output logic                      found_o,
    output logic                      onehot_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set bit wins.
        for (int i = int'(NrRetiredInstr) - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

    assign found_o  = |mask_i;
    // Clearing the lowest set bit leaves zero only for a single-bit mask.
    assign onehot_o = found_o && ((mask_i & (mask_i - NrRetiredInstr'(1))) == '0);

endmodule

// File: rtl/retire_serializer.sv
// Trace encoder ingress: buffers whole commit groups from the CPU commit ports in a FIFO and
// serializes their valid slots onto a single-instruction valid/ready output.
// Optional build macro: RETIRE_SERIALIZER_BYPASS_EN -- a single-slot group arriving at an empty
// FIFO is presented in the same cycle and is only stored if the consumer stalls.
// Ports:
//   clk_i, rst_ni                    : clock, asynchronous active-low reset.
//   valid_i, ilastsize_i, itype_i,
//   iaddr_i                          : per-slot commit data.
//   cause_i, tval_i, priv_i          : per-group common fields.
//   ready_o                          : FIFO not full (informational only).
//   valid_o, ready_i                 : output handshake.
//   ilastsize_o .. priv_o            : selected instruction and its group fields.
//   slot_o                           : commit-port index of the current output.
//   last_o                           : current output is the final valid slot of its group.
//   overflow_o                       : sticky, a group was dropped on a full FIFO.
module retire_serializer
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = 2,
    parameter int unsigned Depth          = 16,
    parameter int unsigned IdxW           = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NrRetiredInstr-1:0]                valid_i,
    input  logic [NrRetiredInstr-1:0]                ilastsize_i,
    input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype_i,
    input  logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr_i,
    input  logic [CAUSE_LEN-1:0]                     cause_i,
    input  logic [XLEN-1:0]                          tval_i,
    input  logic [PRIV_LEN-1:0]                      priv_i,
    output logic                                     ready_o,
    output logic                                     valid_o,
    input  logic                                     ready_i,
    output logic                                     ilastsize_o,
    output logic [ITYPE_LEN-1:0]                     itype_o,
    output logic [XLEN-1:0]                          iaddr_o,
    output logic [CAUSE_LEN-1:0]                     cause_o,
    output logic [XLEN-1:0]                          tval_o,
    output logic [PRIV_LEN-1:0]                      priv_o,
    output logic [IdxW-1:0]                          slot_o,
    output logic                                     last_o,
    output logic                                     overflow_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    ret_group_s                mem_q [Depth];
    ret_group_s                wdata;
    logic [AddrW-1:0]          wptr_q, rptr_q, rptr_nxt;
    logic [AddrW:0]            usage_q;
    logic [NrRetiredInstr-1:0] pending_q, pending_d;
    logic                      overflow_q;

    logic                      fifo_empty, fifo_full;
    logic                      push_req, push, pop, serve, bypass;
    logic [NrRetiredInstr-1:0] pick_mask;
    logic [IdxW-1:0]           pick_idx;
    logic                      pick_found, pick_onehot;
    logic [SlotSelW-1:0]       slot_sel;

    assign fifo_empty = (usage_q == '0);
    assign fifo_full  = (usage_q == (AddrW + 1)'(Depth));
    assign push_req   = |valid_i;
    assign rptr_nxt   = rptr_q + AddrW'(1);

`ifdef RETIRE_SERIALIZER_BYPASS_EN
    assign bypass = fifo_empty && $onehot(valid_i);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction that is accepted immediately never needs storage.
    assign push  = push_req && !fifo_full && !(bypass && ready_i);
    // bypass implies an empty FIFO, so serve/pop only ever act on stored groups.
    assign serve = !fifo_empty && ready_i;
    assign pop   = serve && pick_onehot;

    assign pick_mask = bypass ? valid_i : pending_q;

    retire_slot_picker #(
        .NrRetiredInstr(NrRetiredInstr),
        .IdxW          (IdxW)
    ) u_picker (
        .mask_i  (pick_mask),
        .idx_o   (pick_idx),
        .found_o (pick_found),
        .onehot_o(pick_onehot)
    );

    always_comb begin
        wdata       = '0;
        wdata.valid = MaxNrRetired'(valid_i);
        wdata.cause = cause_i;
        wdata.tval  = tval_i;
        wdata.priv  = priv_i;
        for (int i = 0; i < int'(NrRetiredInstr); i++) begin
            wdata.slot[i].itype     = itype_i[i];
            wdata.slot[i].iaddr     = iaddr_i[i];
            wdata.slot[i].ilastsize = ilastsize_i[i];
        end
    end

    // Pending mask tracks the unserved slots of the head group; it is non-zero exactly when the
    // FIFO holds a group, because empty groups are never stored.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            if (usage_q > (AddrW + 1)'(1)) begin
                pending_d = mem_q[rptr_nxt].valid[NrRetiredInstr-1:0];
            end else if (push) begin
                // The new head is being written this cycle and is not in memory yet.
                pending_d = valid_i;
            end else begin
                pending_d = '0;
            end
        end else if (serve) begin
            pending_d = pending_q & ~(NrRetiredInstr'(1) << pick_idx);
        end else if (fifo_empty && push) begin
            pending_d = valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            usage_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AddrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_nxt;
            end
            if (push && !pop) begin
                usage_q <= usage_q + (AddrW + 1)'(1);
            end else if (pop && !push) begin
                usage_q <= usage_q - (AddrW + 1)'(1);
            end
            pending_q <= pending_d;
            // Space freed by a same-cycle pop is not available to the dropped push.
            if (push_req && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_comb begin
        slot_sel    = SlotSelW'(pick_idx);
        ilastsize_o = 1'b0;
        itype_o     = '0;
        iaddr_o     = '0;
        cause_o     = '0;
        tval_o      = '0;
        priv_o      = '0;
        if (bypass) begin
            ilastsize_o = ilastsize_i[pick_idx];
            itype_o     = itype_i[pick_idx];
            iaddr_o     = iaddr_i[pick_idx];
            cause_o     = cause_i;
            tval_o      = tval_i;
            priv_o      = priv_i;
        end else if (pick_found) begin
            ilastsize_o = mem_q[rptr_q].slot[slot_sel].ilastsize;
            itype_o     = mem_q[rptr_q].slot[slot_sel].itype;
            iaddr_o     = mem_q[rptr_q].slot[slot_sel].iaddr;
            cause_o     = mem_q[rptr_q].cause;
            tval_o      = mem_q[rptr_q].tval;
            priv_o      = mem_q[rptr_q].priv;
        end
    end

    assign valid_o    = pick_found;
    assign slot_o     = pick_idx;
    assign last_o     = pick_onehot;
    assign ready_o    = !fifo_full;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_retire_serializer.sv
// Self-checking bench for retire_serializer (NrRetiredInstr = 2, Depth = 16).
module tb_retire_serializer;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       valid_i;
    logic [1:0]       ilastsize_i;
    logic [1:0][2:0]  itype_i;
    logic [1:0][31:0] iaddr_i;
    logic [4:0]       cause_i;
    logic [31:0]      tval_i;
    logic [1:0]       priv_i;
    logic             ready_o, valid_o, ready_i;
    logic             ilastsize_o;
    logic [2:0]       itype_o;
    logic [31:0]      iaddr_o;
    logic [4:0]       cause_o;
    logic [31:0]      tval_o;
    logic [1:0]       priv_o;
    logic [0:0]       slot_o;
    logic             last_o, overflow_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    retire_serializer #(
        .NrRetiredInstr(2),
        .Depth         (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ilastsize_i(ilastsize_i),
        .itype_i    (itype_i),
        .iaddr_i    (iaddr_i),
        .cause_i    (cause_i),
        .tval_i     (tval_i),
        .priv_i     (priv_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .ilastsize_o(ilastsize_o),
        .itype_o    (itype_o),
        .iaddr_o    (iaddr_o),
        .cause_o    (cause_o),
        .tval_o     (tval_o),
        .priv_o     (priv_o),
        .slot_o     (slot_o),
        .last_o     (last_o),
        .overflow_o (overflow_o)
    );

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [4:0]  cause;
        logic        rdy;
        logic        ev;
        logic        eslot;
        logic        elast;
        logic [31:0] eaddr;
        logic [4:0]  ecause;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [4:0] cause, input logic rdy, input logic ev,
                                input logic eslot, input logic elast, input logic [31:0] eaddr,
                                input logic [4:0] ecause);
        vec_t v;
        v.vld = vld; v.a0 = a0; v.a1 = a1; v.cause = cause; v.rdy = rdy;
        v.ev = ev; v.eslot = eslot; v.elast = elast; v.eaddr = eaddr; v.ecause = ecause;
        return v;
    endfunction

    // Slot-dependent side fields are derived from the group cause so every field is checkable.
    task automatic drive(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [4:0] cause, input logic rdy);
        valid_i    = vld;
        iaddr_i[0] = a0;
        iaddr_i[1] = a1;
        for (int k = 0; k < 2; k++) begin
            itype_i[k]     = 3'(k) ^ cause[2:0];
            ilastsize_i[k] = k[0];
        end
        cause_i = cause;
        tval_i  = {19'd0, cause, 8'd0};
        priv_i  = cause[1:0];
        ready_i = rdy;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic sl, input logic last,
                             input logic [31:0] addr, input logic [4:0] cause);
        logic [2:0]  e_itype;
        logic [31:0] e_tval;
        e_itype = ev ? ({2'b00, sl} ^ cause[2:0]) : 3'd0;
        e_tval  = ev ? {19'd0, cause, 8'd0} : 32'd0;
        check({tag, ".valid"}, 32'(valid_o), 32'(ev));
        check({tag, ".slot"}, 32'(slot_o), 32'(ev & sl));
        check({tag, ".last"}, 32'(last_o), 32'(ev & last));
        check({tag, ".iaddr"}, iaddr_o, ev ? addr : 32'd0);
        check({tag, ".cause"}, 32'(cause_o), ev ? 32'(cause) : 32'd0);
        check({tag, ".tval"}, tval_o, e_tval);
        check({tag, ".itype"}, 32'(itype_o), 32'(e_itype));
        check({tag, ".ilastsize"}, 32'(ilastsize_o), 32'(ev & sl));
        check({tag, ".priv"}, 32'(priv_o), ev ? 32'(cause[1:0]) : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Two-slot group served in order, then back-to-back single-slot groups (slot 1, slot 0),
        // then a two-slot group under a toggling ready.
        vecs[0]  = mk(2'b11, 32'h100, 32'h104, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0);
        vecs[1]  = mk(2'b10, 32'h0,   32'h204, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 5'd1);
        vecs[2]  = mk(2'b01, 32'h300, 32'h0,   5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 5'd1);
        vecs[3]  = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h204, 5'd2);
        vecs[4]  = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 5'd3);
        vecs[5]  = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0);
        vecs[6]  = mk(2'b11, 32'h500, 32'h504, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0);
        vecs[7]  = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 5'd5);
        vecs[8]  = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 5'd5);
        vecs[9]  = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h504, 5'd5);
        vecs[10] = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h504, 5'd5);
        vecs[11] = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h504, 5'd5);
        vecs[12] = mk(2'b00, 32'h0,   32'h0,   5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0);

        rst_ni = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        check_out("reset", 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        check("reset.ready_o", 32'(ready_o), 32'd1);
        check("reset.overflow_o", 32'(overflow_o), 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].vld, vecs[i].a0, vecs[i].a1, vecs[i].cause, vecs[i].rdy);
            @(negedge clk_i);
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eslot, vecs[i].elast,
                      vecs[i].eaddr, vecs[i].ecause);
            check($sformatf("vec%0d.ready_o", i), 32'(ready_o), 32'd1);
            @(posedge clk_i);
            #1;
        end

        // Reset with three groups queued.
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'h700 + 32'(i * 8), 32'h704 + 32'(i * 8), 5'(i), 1'b0);
            @(posedge clk_i);
            #1;
        end
        drive(2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        check("midrst.before.valid_o", 32'(valid_o), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst.async.valid_o", 32'(valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("midrst.valid_o", 32'(valid_o), 32'd0);
        check("midrst.overflow_o", 32'(overflow_o), 32'd0);
        check("midrst.ready_o", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Fill all 16 entries with the output stalled.
        for (int i = 0; i < 16; i++) begin
            drive(2'b01, 32'h1000 + 32'(i * 4), 32'h0, 5'(i), 1'b0);
            @(posedge clk_i);
            #1;
        end
        drive(2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk_i);
        check("full.ready_o", 32'(ready_o), 32'd0);
        check("full.overflow_o", 32'(overflow_o), 32'd0);
        check("full.iaddr_o", iaddr_o, 32'h1000);
        @(posedge clk_i);
        #1;
        // 17th group arrives while the head pops: it must still be dropped.
        drive(2'b01, 32'h2000, 32'h0, 5'd31, 1'b1);
        @(negedge clk_i);
        check("drop.head.iaddr_o", iaddr_o, 32'h1000);
        check("drop.ready_o", 32'(ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 1'b1);
        check("drop.overflow_o", 32'(overflow_o), 32'd1);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk_i);
            check_out($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i * 4), 5'(i));
            @(posedge clk_i);
            #1;
        end
        @(negedge clk_i);
        check("drained.valid_o", 32'(valid_o), 32'd0);
        check("drained.overflow_o", 32'(overflow_o), 32'd1);
        check("drained.ready_o", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Single-slot group into an empty FIFO with ready high.
        drive(2'b01, 32'h600, 32'h0, 5'd6, 1'b1);
        @(negedge clk_i);
`ifdef RETIRE_SERIALIZER_BYPASS_EN
        check_out("bypass.same", 1'b1, 1'b0, 1'b1, 32'h600, 5'd6);
        @(posedge clk_i);
        #1;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 1'b1);
        @(negedge clk_i);
        check("bypass.after.valid_o", 32'(valid_o), 32'd0);
`else
        check("nobypass.same.valid_o", 32'(valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 1'b1);
        @(negedge clk_i);
        check_out("nobypass.next", 1'b1, 1'b0, 1'b1, 32'h600, 5'd6);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("nobypass.after.valid_o", 32'(valid_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
